// File: rtl/ifu_ic_pkg.sv
// Shared IFU icache definitions: tag width default, way count, way-select FSM states.
package ifu_ic_pkg;
    localparam int TAG_W_DEF = 29;
    localparam int NUM_WAYS  = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } waysel_state_e;

    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction
endpackage

// File: rtl/icache_way_cmp.sv
// Single-way tag compare and even-parity check; match does not depend on parity.
module icache_way_cmp #(
    parameter int TAG_W = ifu_ic_pkg::TAG_W_DEF
) (
    input  logic [TAG_W:0]   tag_rd,
    input  logic             vld_bit,
    input  logic [TAG_W-1:0] ptag,
    output logic             match,
    output logic             perr
);
    assign match = vld_bit & (tag_rd[TAG_W-1:0] == ptag);
    assign perr  = vld_bit & (^tag_rd);
endmodule

// File: rtl/icache_waysel_gen.sv
// Icache way-select stage: S0 tag compare into S1 registers, with multi-hit / parity recovery FSM.
module icache_waysel_gen #(
    parameter int TAG_W = ifu_ic_pkg::TAG_W_DEF,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_s0,
    input  logic                 rd_vld_s0,
    input  logic [4*(TAG_W+1)-1:0] tag_rd_s0,
    input  logic [3:0]           vld_bits_s0,
    input  logic [TAG_W-1:0]     ptag_s0,
    input  logic                 tlb_miss_s0,
    input  logic                 inv_ack,
    output logic [3:0]           waysel_buf_s1,
    output logic [3:0]           alltag_err_s1,
    output logic                 tlb_cam_miss_s1,
    output logic                 cam_vld_s1,
    output logic                 hit_s1,
    output logic                 multihit_s1,
    output logic                 stall_req,
    output logic                 inv_req,
    output logic [3:0]           inv_way,
    output logic                 refetch_s1,
    output logic [CNT_W-1:0]     err_cnt
);
    import ifu_ic_pkg::*;

    localparam int WAY_W = TAG_W + 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    waysel_state_e state;
    logic [3:0]    match_s0;
    logic [3:0]    perr_s0;
    logic [2:0]    way_cnt;
    logic          clean;
    logic          trig;
    logic          cap;

    for (genvar i = 0; i < NUM_WAYS; i++) begin : g_way
        icache_way_cmp #(.TAG_W(TAG_W)) u_cmp (
            .tag_rd  (tag_rd_s0[i*WAY_W +: WAY_W]),
            .vld_bit (vld_bits_s0[i]),
            .ptag    (ptag_s0),
            .match   (match_s0[i]),
            .perr    (perr_s0[i])
        );
    end

    // S1 hit classification
    assign way_cnt     = popcnt4(waysel_buf_s1);
    assign clean       = cam_vld_s1 & ~tlb_cam_miss_s1 & ~|alltag_err_s1;
    assign hit_s1      = clean & (way_cnt == 3'd1);
    assign multihit_s1 = clean & (way_cnt > 3'd1);

    // A TLB miss masks parity errors: the fetch is discarded anyway.
    assign trig      = (state == ST_IDLE) & cam_vld_s1 & ~tlb_cam_miss_s1 &
                       ((|alltag_err_s1) | multihit_s1);
    assign cap       = ~stall_s0 & (state == ST_IDLE) & ~trig;
    assign stall_req = trig | (state == ST_REQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            waysel_buf_s1   <= '0;
            alltag_err_s1   <= '0;
            tlb_cam_miss_s1 <= 1'b0;
            cam_vld_s1      <= 1'b0;
            state           <= ST_IDLE;
            inv_req         <= 1'b0;
            inv_way         <= '0;
            refetch_s1      <= 1'b0;
            err_cnt         <= '0;
        end else begin
            refetch_s1 <= 1'b0;
            if (cap) begin
                waysel_buf_s1   <= match_s0;
                alltag_err_s1   <= perr_s0;
                tlb_cam_miss_s1 <= tlb_miss_s0;
                cam_vld_s1      <= rd_vld_s0;
            end
            case (state)
                ST_IDLE: begin
                    if (trig) begin
                        state   <= ST_REQ;
                        inv_req <= 1'b1;
                        inv_way <= alltag_err_s1 | (multihit_s1 ? waysel_buf_s1 : 4'b0000);
                        err_cnt <= sat_inc(err_cnt);
                    end
                end
                ST_REQ: begin
                    if (inv_ack) begin
                        state      <= ST_IDLE;
                        inv_req    <= 1'b0;
                        cam_vld_s1 <= 1'b0;
                        refetch_s1 <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_icache_waysel_gen.sv
// Directed self-checking bench for icache_waysel_gen (counter width 2 to reach saturation quickly).
module tb_icache_waysel_gen;
    localparam int TAG_W = 29;
    localparam int CNT_W = 2;
    localparam int WW    = TAG_W + 1;

    localparam logic [TAG_W-1:0] PT = 29'h0ABC_DEF1;
    localparam logic [TAG_W-1:0] OT = 29'h0123_4567;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall_s0;
    logic              rd_vld_s0;
    logic [4*WW-1:0]   tag_rd_s0;
    logic [3:0]        vld_bits_s0;
    logic [TAG_W-1:0]  ptag_s0;
    logic              tlb_miss_s0;
    logic              inv_ack;
    logic [3:0]        waysel_buf_s1;
    logic [3:0]        alltag_err_s1;
    logic              tlb_cam_miss_s1;
    logic              cam_vld_s1;
    logic              hit_s1;
    logic              multihit_s1;
    logic              stall_req;
    logic              inv_req;
    logic [3:0]        inv_way;
    logic              refetch_s1;
    logic [CNT_W-1:0]  err_cnt;

    int n_pass = 0;
    int n_total = 0;

    icache_waysel_gen #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_s0        (stall_s0),
        .rd_vld_s0       (rd_vld_s0),
        .tag_rd_s0       (tag_rd_s0),
        .vld_bits_s0     (vld_bits_s0),
        .ptag_s0         (ptag_s0),
        .tlb_miss_s0     (tlb_miss_s0),
        .inv_ack         (inv_ack),
        .waysel_buf_s1   (waysel_buf_s1),
        .alltag_err_s1   (alltag_err_s1),
        .tlb_cam_miss_s1 (tlb_cam_miss_s1),
        .cam_vld_s1      (cam_vld_s1),
        .hit_s1          (hit_s1),
        .multihit_s1     (multihit_s1),
        .stall_req       (stall_req),
        .inv_req         (inv_req),
        .inv_way         (inv_way),
        .refetch_s1      (refetch_s1),
        .err_cnt         (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [WW-1:0] good(input logic [TAG_W-1:0] t);
        return {^t, t};
    endfunction

    function automatic logic [WW-1:0] bad(input logic [TAG_W-1:0] t);
        return {~^t, t};
    endfunction

    function automatic logic [4*WW-1:0] pack4(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                                              input logic [WW-1:0] w2, input logic [WW-1:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_s0(input logic vld, input logic [4*WW-1:0] tags,
                            input logic [3:0] vb, input logic tlbm);
        rd_vld_s0   = vld;
        tag_rd_s0   = tags;
        vld_bits_s0 = vb;
        tlb_miss_s0 = tlbm;
    endtask

    task automatic drive_idle();
        drive_s0(1'b0, '0, 4'b0000, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; stall_s0 = 1'b0; inv_ack = 1'b0; ptag_s0 = PT;
        drive_idle();
        tick(); tick();
        n_total++; if (waysel_buf_s1 !== 4'b0000) $display("FAIL reset_waysel got %b want 0000", waysel_buf_s1); else n_pass++;
        n_total++; if (alltag_err_s1 !== 4'b0000) $display("FAIL reset_err got %b want 0000", alltag_err_s1); else n_pass++;
        n_total++; if (cam_vld_s1 !== 1'b0) $display("FAIL reset_cam_vld got %b want 0", cam_vld_s1); else n_pass++;
        n_total++; if (inv_req !== 1'b0 || inv_way !== 4'b0000) $display("FAIL reset_inv got %b/%b want 0/0000", inv_req, inv_way); else n_pass++;
        n_total++; if (refetch_s1 !== 1'b0 || stall_req !== 1'b0) $display("FAIL reset_refetch_stall got %b/%b want 0/0", refetch_s1, stall_req); else n_pass++;
        n_total++; if (err_cnt !== 2'd0) $display("FAIL reset_err_cnt got %0d want 0", err_cnt); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_hit();
        drive_s0(1'b1, pack4(good(OT), good(OT), good(PT), good(OT)), 4'b1111, 1'b0);
        tick();
        drive_idle();
        n_total++; if (waysel_buf_s1 !== 4'b0100) $display("FAIL hit_waysel got %b want 0100", waysel_buf_s1); else n_pass++;
        n_total++; if (hit_s1 !== 1'b1 || multihit_s1 !== 1'b0) $display("FAIL hit_flags got %b/%b want 1/0", hit_s1, multihit_s1); else n_pass++;
        n_total++; if (stall_req !== 1'b0) $display("FAIL hit_stall_req got %b want 0", stall_req); else n_pass++;
        tick();
        n_total++; if (inv_req !== 1'b0 || cam_vld_s1 !== 1'b0) $display("FAIL hit_after got %b/%b want 0/0", inv_req, cam_vld_s1); else n_pass++;
    endtask

    task automatic test_multihit();
        drive_s0(1'b1, pack4(good(PT), good(OT), good(OT), good(PT)), 4'b1111, 1'b0);
        tick();
        drive_idle();
        n_total++; if (multihit_s1 !== 1'b1 || hit_s1 !== 1'b0) $display("FAIL mh_flags got %b/%b want 1/0", multihit_s1, hit_s1); else n_pass++;
        n_total++; if (stall_req !== 1'b1 || inv_req !== 1'b0) $display("FAIL mh_trig_cycle got %b/%b want 1/0", stall_req, inv_req); else n_pass++;
        tick();
        n_total++; if (inv_req !== 1'b1 || inv_way !== 4'b1001) $display("FAIL mh_inv got %b/%b want 1/1001", inv_req, inv_way); else n_pass++;
        n_total++; if (err_cnt !== 2'd1) $display("FAIL mh_err_cnt got %0d want 1", err_cnt); else n_pass++;
        tick(); tick();
        n_total++; if (inv_req !== 1'b1 || inv_way !== 4'b1001 || waysel_buf_s1 !== 4'b1001) $display("FAIL mh_hold got %b/%b/%b want 1/1001/1001", inv_req, inv_way, waysel_buf_s1); else n_pass++;
        n_total++; if (stall_req !== 1'b1) $display("FAIL mh_stall_hold got %b want 1", stall_req); else n_pass++;
        inv_ack = 1'b1;
        tick();
        inv_ack = 1'b0;
        n_total++; if (inv_req !== 1'b0 || refetch_s1 !== 1'b1 || cam_vld_s1 !== 1'b0) $display("FAIL mh_ack got %b/%b/%b want 0/1/0", inv_req, refetch_s1, cam_vld_s1); else n_pass++;
        n_total++; if (stall_req !== 1'b0) $display("FAIL mh_ack_stall got %b want 0", stall_req); else n_pass++;
        tick();
        n_total++; if (refetch_s1 !== 1'b0) $display("FAIL mh_refetch_pulse got %b want 0", refetch_s1); else n_pass++;
    endtask

    task automatic test_parity();
        drive_s0(1'b1, pack4(good(OT), bad(PT), good(OT), good(OT)), 4'b1111, 1'b0);
        tick();
        drive_idle();
        n_total++; if (alltag_err_s1 !== 4'b0010 || waysel_buf_s1 !== 4'b0010) $display("FAIL par_s1 got %b/%b want 0010/0010", alltag_err_s1, waysel_buf_s1); else n_pass++;
        n_total++; if (multihit_s1 !== 1'b0 || hit_s1 !== 1'b0 || stall_req !== 1'b1) $display("FAIL par_flags got %b/%b/%b want 0/0/1", multihit_s1, hit_s1, stall_req); else n_pass++;
        tick();
        n_total++; if (inv_req !== 1'b1 || inv_way !== 4'b0010 || err_cnt !== 2'd2) $display("FAIL par_inv got %b/%b/%0d want 1/0010/2", inv_req, inv_way, err_cnt); else n_pass++;
        inv_ack = 1'b1;
        tick();
        inv_ack = 1'b0;
        n_total++; if (inv_req !== 1'b0 || refetch_s1 !== 1'b1) $display("FAIL par_early_ack got %b/%b want 0/1", inv_req, refetch_s1); else n_pass++;
        tick();
        n_total++; if (refetch_s1 !== 1'b0) $display("FAIL par_refetch_pulse got %b want 0", refetch_s1); else n_pass++;
    endtask

    task automatic test_tlb_miss();
        drive_s0(1'b1, pack4(bad(PT), good(OT), good(OT), good(OT)), 4'b1111, 1'b1);
        tick();
        drive_idle();
        n_total++; if (tlb_cam_miss_s1 !== 1'b1 || alltag_err_s1 !== 4'b0001) $display("FAIL tlb_s1 got %b/%b want 1/0001", tlb_cam_miss_s1, alltag_err_s1); else n_pass++;
        n_total++; if (stall_req !== 1'b0) $display("FAIL tlb_stall_req got %b want 0", stall_req); else n_pass++;
        inv_ack = 1'b1;
        tick();
        inv_ack = 1'b0;
        n_total++; if (inv_req !== 1'b0 || err_cnt !== 2'd2 || refetch_s1 !== 1'b0) $display("FAIL tlb_no_trig got %b/%0d/%b want 0/2/0", inv_req, err_cnt, refetch_s1); else n_pass++;
    endtask

    task automatic test_stall();
        drive_s0(1'b1, pack4(good(OT), good(OT), good(PT), good(OT)), 4'b1111, 1'b0);
        tick();
        n_total++; if (waysel_buf_s1 !== 4'b0100) $display("FAIL stall_pre got %b want 0100", waysel_buf_s1); else n_pass++;
        stall_s0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_s0(1'b1, pack4(good(PT), good(PT), good(PT), good(PT)), 4'b0001 << i, 1'b0);
            tick();
            n_total++; if (waysel_buf_s1 !== 4'b0100 || cam_vld_s1 !== 1'b1) $display("FAIL stall_hold_%0d got %b/%b want 0100/1", i, waysel_buf_s1, cam_vld_s1); else n_pass++;
        end
        stall_s0 = 1'b0;
        tick();
        n_total++; if (waysel_buf_s1 !== 4'b1000 || hit_s1 !== 1'b1) $display("FAIL stall_release got %b/%b want 1000/1", waysel_buf_s1, hit_s1); else n_pass++;
        drive_idle();
        tick();
    endtask

    task automatic test_saturate_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++; if (err_cnt !== 2'd0) $display("FAIL sat_start got %0d want 0", err_cnt); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            drive_s0(1'b1, pack4(good(PT), good(PT), good(OT), good(OT)), 4'b1111, 1'b0);
            tick();
            drive_idle();
            tick();
            inv_ack = 1'b1;
            tick();
            inv_ack = 1'b0;
            if (k == 2) begin
                n_total++; if (err_cnt !== 2'd3) $display("FAIL sat_three got %0d want 3", err_cnt); else n_pass++;
            end
        end
        n_total++; if (err_cnt !== 2'd3) $display("FAIL sat_hold got %0d want 3", err_cnt); else n_pass++;
        drive_s0(1'b1, pack4(good(PT), good(PT), good(OT), good(OT)), 4'b1111, 1'b0);
        tick();
        drive_idle();
        tick();
        n_total++; if (inv_req !== 1'b1 || inv_way !== 4'b0011) $display("FAIL rstreq_pre got %b/%b want 1/0011", inv_req, inv_way); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++; if (inv_req !== 1'b0 || inv_way !== 4'b0000 || stall_req !== 1'b0) $display("FAIL rstreq_abort got %b/%b/%b want 0/0000/0", inv_req, inv_way, stall_req); else n_pass++;
        inv_ack = 1'b1;
        tick();
        inv_ack = 1'b0;
        n_total++; if (refetch_s1 !== 1'b0 || inv_req !== 1'b0) $display("FAIL rstreq_idle_ack got %b/%b want 0/0", refetch_s1, inv_req); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_hit();
        test_multihit();
        test_parity();
        test_tlb_miss();
        test_stall();
        test_saturate_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
